mpmc10_resv_tbl: RTL
====================

Name: mpmc10_resv_tbl

Overview:
Reservation table for the mpmc10 multi-port memory controller: records load-reserved (LR) address reservations per channel and kills them on conflicting writes. Drives the resv_ch/resv_adr arrays that the controller's store-conditional (SC) status-bit logic compares against. Instantiated once in the controller and updated on each accepted request while the controller is in IDLE.

Parameters:
NAR, mpmc10_pkg::NAR (default 2), number of reservation entries (1..15).
NOCH, 4'hF, channel sentinel driven on resv_ch for invalid entries. Real channels are 0..14.

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
state  in  4  controller state; table updates only when state==mpmc10_pkg::IDLE
req  in  1  request accepted this cycle (qualifies ch/adr/we/sr/cr)
ch  in  4  requesting channel
adr  in  32  request byte address; granule is adr[31:5]
we  in  1  request is a write
sr  in  1  set reservation (LR read)
cr  in  1  conditional write (SC)
resv_ch  out  4 x NAR  owner channel per entry, NOCH if invalid
resv_adr  out  32 x NAR  reserved address per entry, {adr[31:5],5'b0}; 0 if invalid
resv_vld  out  NAR  entry valid bits
sc_ok  out  1  registered: last SC found a matching reservation

Behaviour:
- Reset (async, rst_n low): all entries invalid; resv_ch=NOCH and resv_adr=0 for every entry; resv_vld=0; sc_ok=0; victim pointer=0. Mid-operation reset discards all reservations immediately.
- Update event: posedge clk with state==IDLE && req. With no update event, all state holds. All outputs are registered and reflect the update one cycle after the event.
- hit(ch,adr): some valid entry i has resv_ch[i]==ch and resv_adr[i][31:5]==adr[31:5]. Always evaluated on pre-update contents.
- LR (sr && !we):
  - If ch already owns a valid entry, overwrite that entry's address (one reservation per channel).
  - Otherwise fill the lowest-index invalid entry.
  - If the table is full, replace the entry at the victim pointer, then advance the pointer mod NAR. The pointer advances only on replacement.
- Plain write (we && !cr): invalidate every valid entry whose granule matches adr[31:5], including the writer's own entry.
- SC (we && cr):
  - sc_ok <= hit(ch,adr).
  - If hit: invalidate all entries matching the granule, any owner.
  - If miss: memory is not written, so other channels' entries are untouched.
  - In both cases, invalidate every entry owned by ch; an SC always consumes the channel's reservation.
- sc_ok changes only on SC events and otherwise holds.
- sr && we together: treated as a write; sr is ignored (flagged by a simulation assertion).
- Read without sr: no effect.
- Invariant: at most one valid entry per channel. A request with ch==NOCH is ignored (assertion).
- Each entry's next state is decided independently per cycle. Invalidate and set never target the same entry in one event, because LR and write are mutually exclusive.

Decomposition:
- mpmc10_pkg holds NAR, NOCH, IDLE, TRUE/FALSE and a typedef resv_entry_t {logic v; logic [3:0] ch; logic [31:5] gadr;}.
- One sub-module, mpmc10_resv_alloc: combinational selection of the owned entry, the first free entry and the full flag from the vld/ch vectors.
- The victim pointer stays in the parent.

Test Plan:
- Reset, then LR ch=2 adr=0x1000_0040 → next cycle resv_vld=01, resv_ch[0]=2, resv_adr[0]=0x1000_0040; resv_ch[1]=NOCH.
- LR ch=2 at 0x40, then LR ch=2 at 0x80 → entry 0 holds 0x80; entry 1 stays invalid.
- LR ch=1 at 0x100 and LR ch=3 at 0x200 (table full, NAR=2), then LR ch=5 at 0x300 → entry 0 becomes ch5/0x300 and the pointer becomes 1. A further LR ch=6 at 0x400 replaces entry 1.
- LR ch=1 at 0x100, then plain write by ch=4 to 0x11C (same granule) → entry invalidated. A write to 0x120 instead leaves it valid.
- LR ch=1 at 0x100 and LR ch=3 at 0x100, then SC ch=1 to 0x104 → sc_ok=1 and both entries invalid. A repeat SC ch=1 gives sc_ok=0.
- LR ch=3 at 0x200, then SC ch=1 to 0x200 (ch1 holds no reservation) → sc_ok=0 and the ch3 entry survives. Same sequence with state!=IDLE → no change. Assert rst_n mid-sequence → all entries invalid at once.

Source files
------------

// File: rtl/mpmc10_pkg.sv
// ============================================================================
// Module  : mpmc10_pkg
// Brief   : Shared constants and types for the mpmc10 reservation table.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mpmc10_pkg;

   localparam int          NAR    = 2;
   localparam int          NAR_IW = (NAR > 1) ? $clog2(NAR) : 1;
   localparam logic [3:0]  NOCH   = 4'hF;
   localparam logic [3:0]  IDLE   = 4'd0;
   localparam logic        TRUE   = 1'b1;
   localparam logic        FALSE  = 1'b0;

   typedef struct packed {
      logic        v;
      logic [3:0]  ch;
      logic [31:5] gadr;
   } resv_entry_t;

endpackage

`default_nettype wire

// File: rtl/mpmc10_resv_tbl_if.sv
// ============================================================================
// Module  : mpmc10_resv_tbl_if
// Brief   : Request bus into, and reservation view out of, the reservation table.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mpmc10_resv_tbl_if;

   logic [3:0]                              state;
   logic                                    req;
   logic [3:0]                              ch;
   logic [31:0]                             adr;
   logic                                    we;
   logic                                    sr;
   logic                                    cr;
   logic [mpmc10_pkg::NAR-1:0][3:0]         resv_ch;
   logic [mpmc10_pkg::NAR-1:0][31:0]        resv_adr;
   logic [mpmc10_pkg::NAR-1:0]              resv_vld;
   logic                                    sc_ok;

   modport master (
      output state, req, ch, adr, we, sr, cr,
      input  resv_ch, resv_adr, resv_vld, sc_ok
   );

   modport slave (
      input  state, req, ch, adr, we, sr, cr,
      output resv_ch, resv_adr, resv_vld, sc_ok
   );

endinterface

`default_nettype wire

// File: rtl/mpmc10_resv_alloc.sv
// ============================================================================
// Module  : mpmc10_resv_alloc
// Brief   : Finds the entry owned by a channel, the lowest free entry and full.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mpmc10_resv_alloc
   import mpmc10_pkg::*;
(
   input  wire logic [NAR-1:0]        vld_i,
   input  wire logic [NAR-1:0][3:0]   ch_i,
   input  wire logic [3:0]            req_ch_i,
   output logic                       own_hit_o,
   output logic [NAR_IW-1:0]          own_idx_o,
   output logic                       free_hit_o,
   output logic [NAR_IW-1:0]          free_idx_o,
   output logic                       full_o
);

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      own_hit_o  = FALSE;
      own_idx_o  = '0;
      free_hit_o = FALSE;
      free_idx_o = '0;
      for (int i = NAR - 1; i >= 0; i--) begin
         if (vld_i[i] && (ch_i[i] == req_ch_i)) begin
            own_hit_o = TRUE;
            own_idx_o = NAR_IW'(i);
         end
         if (!vld_i[i]) begin
            free_hit_o = TRUE;
            free_idx_o = NAR_IW'(i);
         end
      end
   end

   assign full_o = &vld_i;

endmodule

`default_nettype wire

// File: rtl/mpmc10_resv_tbl.sv
// ============================================================================
// Module  : mpmc10_resv_tbl
// Brief   : LR reservation table; kills reservations on conflicting writes/SC.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mpmc10_resv_tbl
   import mpmc10_pkg::*;
(
   input  wire logic          clk,
   input  wire logic          rst_n,
   mpmc10_resv_tbl_if.slave   bus
);

   localparam resv_entry_t C_EMPTY = '{v: 1'b0, ch: NOCH, gadr: '0};

   resv_entry_t           ent_q [NAR];
   resv_entry_t           ent_d [NAR];
   logic [NAR_IW-1:0]     vptr_q, vptr_d;
   logic                  sc_ok_q, sc_ok_d;

   logic [NAR-1:0]        w_vld;
   logic [NAR-1:0][3:0]   w_ch;
   logic [NAR-1:0]        w_gmatch;
   logic [NAR-1:0]        w_own;
   logic                  w_own_hit, w_free_hit, w_full;
   logic [NAR_IW-1:0]     w_own_idx, w_free_idx, w_tgt;
   logic                  w_upd, w_lr, w_wr, w_sc, w_hit;
   logic                  w_unused_lo;

   assign w_unused_lo = ^bus.adr[4:0];

   generate
      for (genvar g = 0; g < NAR; g++) begin : g_ent
         assign w_vld[g]        = ent_q[g].v;
         assign w_ch[g]         = ent_q[g].ch;
         assign w_gmatch[g]     = ent_q[g].v && (ent_q[g].gadr == bus.adr[31:5]);
         assign w_own[g]        = ent_q[g].v && (ent_q[g].ch == bus.ch);
         // Invalid entries are stored as NOCH/0, so outputs come straight off flops.
         assign bus.resv_ch[g]  = ent_q[g].ch;
         assign bus.resv_adr[g] = {ent_q[g].gadr, 5'b0};
         assign bus.resv_vld[g] = ent_q[g].v;
      end
   endgenerate

   assign bus.sc_ok = sc_ok_q;

   mpmc10_resv_alloc u_alloc (
      .vld_i      (w_vld),
      .ch_i       (w_ch),
      .req_ch_i   (bus.ch),
      .own_hit_o  (w_own_hit),
      .own_idx_o  (w_own_idx),
      .free_hit_o (w_free_hit),
      .free_idx_o (w_free_idx),
      .full_o     (w_full)
   );

   assign w_upd = (bus.state == IDLE) && bus.req && (bus.ch != NOCH);
   assign w_lr  = w_upd && bus.sr && !bus.we;
   assign w_wr  = w_upd && bus.we && !bus.cr;
   assign w_sc  = w_upd && bus.we && bus.cr;
   assign w_hit = |(w_gmatch & w_own);

   always_comb begin
      w_tgt = vptr_q;
      if (w_own_hit)
         w_tgt = w_own_idx;
      else if (w_free_hit)
         w_tgt = w_free_idx;
   end

   always_comb begin
      vptr_d  = vptr_q;
      sc_ok_d = sc_ok_q;
      for (int i = 0; i < NAR; i++) begin
         ent_d[i] = ent_q[i];
         if (w_lr && (w_tgt == NAR_IW'(i)))
            ent_d[i] = '{v: 1'b1, ch: bus.ch, gadr: bus.adr[31:5]};
         else if ((w_wr && w_gmatch[i]) ||
                  (w_sc && ((w_hit && w_gmatch[i]) || w_own[i])))
            ent_d[i] = C_EMPTY;
      end
      if (w_lr && !w_own_hit && w_full)
         vptr_d = (vptr_q == NAR_IW'(NAR - 1)) ? '0 : vptr_q + 1'b1;
      if (w_sc)
         sc_ok_d = w_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NAR; i++)
            ent_q[i] <= C_EMPTY;
         vptr_q  <= '0;
         sc_ok_q <= 1'b0;
      end else begin
         for (int i = 0; i < NAR; i++)
            ent_q[i] <= ent_d[i];
         vptr_q  <= vptr_d;
         sc_ok_q <= sc_ok_d;
      end
   end

   a_no_sr_with_we: assert property (@(posedge clk) disable iff (!rst_n)
      !((bus.state == IDLE) && bus.req && bus.sr && bus.we));

   a_no_noch_req: assert property (@(posedge clk) disable iff (!rst_n)
      !((bus.state == IDLE) && bus.req && (bus.ch == NOCH)));

endmodule

`default_nettype wire
